shift_rx_fsm: RTL



---
 rtl/shift_uart_pkg.sv | 21 ++
 rtl/shift_rx_sync.sv | 56 +++++
 rtl/shift_rx_fsm.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/shift_uart_pkg.sv
// ---------------------------------------------------------------------------
// shift_uart_pkg
// Definitions shared by the shift-register UART receiver and transmitter.
//   rx_state_t          : receiver FSM states (3-bit encoding)
//   DEFAULT_DATA_BITS   : default data bits per frame (8)
//   DEFAULT_OVERSAMPLE  : default baud_clk cycles per bit (16)
// ---------------------------------------------------------------------------
package shift_uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_t;

    localparam int DEFAULT_DATA_BITS  = 8;
    localparam int DEFAULT_OVERSAMPLE = 16;

endpackage

// File: rtl/shift_rx_sync.sv
// ---------------------------------------------------------------------------
// shift_rx_sync
// Brings the asynchronous FTDI RX line into the baud_clk domain and produces
// the bit value used at each FSM sample point.
//   baud_clk : clock
//   rst      : asynchronous active-high reset
//   ftdi_rx  : raw serial line (idles high)
//   rx_s     : synchronised line, two flops after the pin
//   sample   : value to use at a sample point
// Build option SHIFT_RX_MAJORITY_EN: when defined, sample is the majority of
// the last three rx_s values; otherwise sample is rx_s itself.
// ---------------------------------------------------------------------------
module shift_rx_sync (
    input  logic baud_clk,
    input  logic rst,
    input  logic ftdi_rx,
    output logic rx_s,
    output logic sample
);

    logic [1:0] sync_q;

    // Reset to the idle (high) level so reset never looks like a start bit.
    always_ff @(posedge baud_clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], ftdi_rx};
        end
    end

    assign rx_s = sync_q[1];

`ifdef SHIFT_RX_MAJORITY_EN
    logic [1:0] hist_q;
    logic [2:0] window;

    always_ff @(posedge baud_clk or posedge rst) begin
        if (rst) begin
            hist_q <= 2'b11;
        end else begin
            hist_q <= {hist_q[0], rx_s};
        end
    end

    // The three-value history is the current rx_s plus the two before it,
    // so the vote lands on the same cycle as an unfiltered sample would.
    assign window = {hist_q, rx_s};
    assign sample = (window[0] & window[1]) |
                    (window[0] & window[2]) |
                    (window[1] & window[2]);
`else
    assign sample = rx_s;
`endif

endmodule

// File: rtl/shift_rx_fsm.sv
// ---------------------------------------------------------------------------
// shift_rx_fsm
// UART receive deserializer: finds the start bit on the oversampled FTDI RX
// line, recovers an LSB-first 8N1 frame and strobes the result.
//   baud_clk : clock, OVERSAMPLE x baud rate
//   rst      : asynchronous active-high reset
//   ftdi_rx  : serial input, idles high
//   rx_data  : last correctly framed data word (LSB received first)
//   rx_valid : one-cycle pulse, rx_data updated
//   rx_err   : one-cycle pulse, stop bit sampled low
//   rx_busy  : high whenever the FSM is not idle
// Build option SHIFT_RX_MAJORITY_EN selects 3-sample majority voting in
// shift_rx_sync; timing is identical either way.
// ---------------------------------------------------------------------------
module shift_rx_fsm
    import shift_uart_pkg::*;
#(
    parameter int DATA_BITS  = DEFAULT_DATA_BITS,
    parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
    input  logic                 baud_clk,
    input  logic                 rst,
    input  logic                 ftdi_rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_err,
    output logic                 rx_busy
);

    localparam int HALF   = OVERSAMPLE / 2;
    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = $clog2(DATA_BITS + 1);

    localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(HALF - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

    logic rx_s;
    logic sample;

    rx_state_t             state_q, state_d;
    logic [TICK_W-1:0]     tick_q, tick_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic [DATA_BITS-1:0]  shreg_q, shreg_d;
    logic [DATA_BITS-1:0]  data_d;
    logic                  valid_d;
    logic                  err_d;

    shift_rx_sync u_sync (
        .baud_clk (baud_clk),
        .rst      (rst),
        .ftdi_rx  (ftdi_rx),
        .rx_s     (rx_s),
        .sample   (sample)
    );

    always_ff @(posedge baud_clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            tick_q   <= '0;
            bit_q    <= '0;
            shreg_q  <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;
        end else begin
            state_q  <= state_d;
            tick_q   <= tick_d;
            bit_q    <= bit_d;
            shreg_q  <= shreg_d;
            rx_data  <= data_d;
            rx_valid <= valid_d;
            rx_err   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        data_d  = rx_data;
        valid_d = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                tick_d = '0;
                bit_d  = '0;
                if (!rx_s) begin
                    state_d = START;
                end
            end

            // Half a bit in, a line that has gone back high was a glitch.
            START: begin
                if (tick_q == TICK_HALF) begin
                    tick_d  = '0;
                    state_d = sample ? IDLE : DATA;
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end

            DATA: begin
                if (tick_q == TICK_LAST) begin
                    tick_d  = '0;
                    shreg_d = {sample, shreg_q[DATA_BITS-1:1]};
                    if (bit_q == BIT_LAST) begin
                        bit_d   = '0;
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end

            // Returning to IDLE at mid stop bit leaves half a bit of slack
            // to catch a back-to-back start edge.
            STOP: begin
                if (tick_q == TICK_LAST) begin
                    tick_d = '0;
                    if (sample) begin
                        data_d  = shreg_q;
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = BREAK;
                    end
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end

            // A held-low line must go high before a new start is accepted.
            BREAK: begin
                tick_d = '0;
                if (rx_s) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rx_busy = (state_q != IDLE);

endmodule
